// File: rtl/fg_waveform_gen_mc.sv
// Trapezoid/PWM waveform generator with its own period counter and per-period settings shadow.
// Optional burst mode is enabled by defining FG_WAVEFORM_BURST_EN.
module fg_waveform_gen_mc #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16,
  parameter int unsigned BURST_BITWIDTH    = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         clk_en_i,
  input  logic                         enable_i,
  input  logic [COUNTER_BITWIDTH-1:0]  period_i,
  input  logic [COUNTER_BITWIDTH-1:0]  on_time_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] amplitude_i,
  input  logic [WAVEFORM_BITWIDTH:0]   offset_i,
  input  logic                         invert_i,
  input  logic [BURST_BITWIDTH-1:0]    burst_len_i,
  output logic [WAVEFORM_BITWIDTH:0]   out_o,
  output logic [COUNTER_BITWIDTH-1:0]  cr_o,
  output logic [2:0]                   state_o,
  output logic                         period_start_o,
  output logic                         done_o
);
  localparam int unsigned W = WAVEFORM_BITWIDTH;
  localparam int unsigned C = COUNTER_BITWIDTH;
  localparam logic signed [W+1:0] SAT_MAX = {2'b00, {W{1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {2'b11, {W{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_ON   = 3'd2,
    ST_FALL = 3'd3,
    ST_LOW  = 3'd4
  } state_t;

  function automatic logic [W:0] sat_fn(input logic [W:0] offset, input logic [W-1:0] val,
                                        input logic invert);
    logic signed [W+1:0] mag;
    logic signed [W+1:0] sum;
    mag = $signed({2'b00, val});
    sum = $signed({offset[W], offset}) + (invert ? -mag : mag);
    if (sum > SAT_MAX) begin
      return {1'b0, {W{1'b1}}};
    end else if (sum < SAT_MIN) begin
      return {1'b1, {W{1'b0}}};
    end else begin
      return sum[W:0];
    end
  endfunction

  state_t         state_r, state_next_s;
  logic [C-1:0]   cr_r, period_sh_r, on_time_sh_r;
  logic [W-1:0]   val_r, val_next_s, k_rise_sh_r, k_fall_sh_r, amp_sh_r;
  logic [W:0]     offset_sh_r, out_r, step_s, addsub_s;
  logic           invert_sh_r, period_start_r, done_r;
  logic           rising_s, wrap_s, start_s, burst_done_s, load_sh_s;

`ifdef FG_WAVEFORM_BURST_EN
  logic [BURST_BITWIDTH-1:0] burst_len_sh_r, burst_cnt_r;
  logic                      lock_r;
`else
  logic unused_burst_s;
  assign unused_burst_s = ^burst_len_i;
`endif

  // Region decode, shared add/subtract step and next value/state
  always_comb begin
    rising_s     = (cr_r < on_time_sh_r);
    wrap_s       = (cr_r == period_sh_r);
    step_s       = rising_s ? {1'b0, k_rise_sh_r} : {1'b0, k_fall_sh_r};
    addsub_s     = {1'b0, val_r} + (rising_s ? step_s : (~step_s + {{W{1'b0}}, 1'b1}));
    val_next_s   = {W{1'b0}};
    state_next_s = ST_IDLE;
    if (rising_s) begin
      if ((k_rise_sh_r == {W{1'b0}}) || (addsub_s >= {1'b0, amp_sh_r})) begin
        val_next_s = amp_sh_r;
      end else begin
        val_next_s = addsub_s[W-1:0];
      end
      state_next_s = (val_next_s == amp_sh_r) ? ST_ON : ST_RISE;
    end else begin
      // negative difference shows up as the top bit of the widened result
      if ((k_fall_sh_r == {W{1'b0}}) || addsub_s[W]) begin
        val_next_s = {W{1'b0}};
      end else begin
        val_next_s = addsub_s[W-1:0];
      end
      state_next_s = (val_next_s == {W{1'b0}}) ? ST_LOW : ST_FALL;
    end
  end

  // Start, burst termination and shadow-load qualification
  always_comb begin
`ifdef FG_WAVEFORM_BURST_EN
    start_s      = (state_r == ST_IDLE) && enable_i && !lock_r;
    burst_done_s = (state_r != ST_IDLE) && enable_i && wrap_s &&
                   (burst_len_sh_r != {BURST_BITWIDTH{1'b0}}) &&
                   ((burst_cnt_r + {{(BURST_BITWIDTH-1){1'b0}}, 1'b1}) == burst_len_sh_r);
`else
    start_s      = (state_r == ST_IDLE) && enable_i;
    burst_done_s = 1'b0;
`endif
    load_sh_s = start_s || ((state_r != ST_IDLE) && enable_i && wrap_s && !burst_done_s);
  end

  // Settings shadow, refreshed only at a start or a wrap
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      period_sh_r  <= {C{1'b0}};
      on_time_sh_r <= {C{1'b0}};
      k_rise_sh_r  <= {W{1'b0}};
      k_fall_sh_r  <= {W{1'b0}};
      amp_sh_r     <= {W{1'b0}};
      offset_sh_r  <= {(W+1){1'b0}};
      invert_sh_r  <= 1'b0;
    end else if (clk_en_i && load_sh_s) begin
      period_sh_r  <= period_i;
      on_time_sh_r <= on_time_i;
      k_rise_sh_r  <= k_rise_i;
      k_fall_sh_r  <= k_fall_i;
      amp_sh_r     <= amplitude_i;
      offset_sh_r  <= offset_i;
      invert_sh_r  <= invert_i;
    end
  end

`ifdef FG_WAVEFORM_BURST_EN
  // Burst length latch, wrap counter and re-arm lock
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      burst_len_sh_r <= {BURST_BITWIDTH{1'b0}};
      burst_cnt_r    <= {BURST_BITWIDTH{1'b0}};
      lock_r         <= 1'b0;
    end else if (clk_en_i) begin
      if (start_s) begin
        burst_len_sh_r <= burst_len_i;
        burst_cnt_r    <= {BURST_BITWIDTH{1'b0}};
      end else if (load_sh_s) begin
        burst_cnt_r <= burst_cnt_r + {{(BURST_BITWIDTH-1){1'b0}}, 1'b1};
      end
      if (!enable_i) begin
        lock_r <= 1'b0;
      end else if (burst_done_s) begin
        lock_r <= 1'b1;
      end
    end
  end
`endif

  // Main FSM with counter, waveform value and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r        <= ST_IDLE;
      cr_r           <= {C{1'b0}};
      val_r          <= {W{1'b0}};
      out_r          <= {(W+1){1'b0}};
      period_start_r <= 1'b0;
      done_r         <= 1'b0;
    end else if (clk_en_i) begin
      out_r          <= sat_fn(offset_sh_r, val_r, invert_sh_r);
      period_start_r <= 1'b0;
      done_r         <= 1'b0;
      if (state_r == ST_IDLE) begin
        if (start_s) begin
          state_r        <= ST_RISE;
          cr_r           <= {C{1'b0}};
          val_r          <= {W{1'b0}};
          period_start_r <= 1'b1;
        end
      end else if (!enable_i || burst_done_s) begin
        state_r <= ST_IDLE;
        cr_r    <= {C{1'b0}};
        val_r   <= {W{1'b0}};
        done_r  <= burst_done_s;
      end else begin
        val_r   <= val_next_s;
        state_r <= state_next_s;
        if (wrap_s) begin
          cr_r           <= {C{1'b0}};
          period_start_r <= 1'b1;
        end else begin
          cr_r <= cr_r + {{(C-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign out_o          = out_r;
  assign cr_o           = cr_r;
  assign state_o        = state_r;
  assign period_start_o = period_start_r;
  assign done_o         = done_r;
endmodule

// File: tb/tb_fg_waveform_gen_mc.sv
// Directed self-checking bench for fg_waveform_gen_mc (burst steps build with FG_WAVEFORM_BURST_EN).
module tb_fg_waveform_gen_mc;
  localparam int CW = 32;
  localparam int WW = 16;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rstn, clk_en, enable, invert;
  logic [CW-1:0] period, on_time, cr;
  logic [WW-1:0] k_rise, k_fall, amp;
  logic [WW:0]   offset, out;
  logic [BW-1:0] burst_len;
  logic [2:0]    state;
  logic          ps, done;

  int n_assert = 0;
  int n_fail   = 0;
  int st_t[10]  = '{1, 2, 2, 2, 2, 3, 3, 4, 4, 4};
  int out_t[10] = '{0, 50, 100, 100, 100, 100, 60, 20, 0, 0};
  int cont_t[10] = '{0, 50, 100, 100, 100, 100, 90, 80, 70, 60};

  always #5 clk = ~clk;

  fg_waveform_gen_mc #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW), .BURST_BITWIDTH(BW)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable),
    .period_i(period), .on_time_i(on_time), .k_rise_i(k_rise), .k_fall_i(k_fall),
    .amplitude_i(amp), .offset_i(offset), .invert_i(invert), .burst_len_i(burst_len),
    .out_o(out), .cr_o(cr), .state_o(state), .period_start_o(ps), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_out(input string tag, input int exp);
    chk(tag, 64'($signed(out)), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup();
    period = 32'd9; on_time = 32'd5; k_rise = 16'd50; k_fall = 16'd40;
    amp = 16'd100; offset = 17'd0; invert = 1'b0; burst_len = 8'd0;
  endtask

  task automatic restart(input string tag);
    enable = 1'b0;
    tick();
    chk({tag, " idle"}, 64'(state), 64'd0);
    enable = 1'b1;
    tick();
    chk({tag, " start state"}, 64'(state), 64'd1);
    chk({tag, " start cr"}, 64'(cr), 64'd0);
    chk({tag, " start pulse"}, 64'(ps), 64'd1);
  endtask

  initial begin
    rstn = 1'b0; clk_en = 1'b1; enable = 1'b0;
    setup();
    #12;
    chk_out("reset out", 0);
    chk("reset cr", 64'(cr), 64'd0);
    chk("reset state", 64'(state), 64'd0);
    chk("reset pulse", 64'(ps), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // basic shape over two periods
    restart("basic");
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 10; c++) begin
        tick();
        chk($sformatf("basic p%0d c%0d state", p, c), 64'(state), 64'(st_t[c]));
        chk($sformatf("basic p%0d c%0d cr", p, c), 64'(cr), 64'((c + 1) % 10));
        chk_out($sformatf("basic p%0d c%0d out", p, c), out_t[c]);
        chk($sformatf("basic p%0d c%0d pulse", p, c), 64'(ps), 64'(c == 9));
        chk($sformatf("basic p%0d c%0d done", p, c), 64'(done), 64'd0);
      end
    end

    // unfinished fall continues into the next period
    setup(); k_fall = 16'd10;
    restart("cont");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("cont c%0d out", c), cont_t[c]);
    end
    chk("cont wrap pulse", 64'(ps), 64'd1);
    chk("cont wrap state", 64'(state), 64'd3);
    tick();
    chk_out("cont next c0 out", 50);
    chk("cont next c0 state", 64'(state), 64'd2);
    tick();
    chk_out("cont next c1 out", 100);

    // amplitude change mid-period takes effect only after the wrap
    setup();
    restart("shadow");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("shadow c%0d state", c), 64'(state), 64'(st_t[c]));
      chk_out($sformatf("shadow c%0d out", c), out_t[c]);
      if (c == 2) amp = 16'd40;
    end
    tick();
    chk("shadow next c0 state", 64'(state), 64'd2);
    tick();
    chk_out("shadow next c1 out", 40);
    chk("shadow next c1 state", 64'(state), 64'd2);
    tick();
    chk_out("shadow next c2 out", 40);

    // inverted full-scale with negative offset saturates low
    setup(); offset = -17'sd30; invert = 1'b1; amp = 16'hFFFF; k_rise = 16'd0;
    restart("inv");
    tick();
    chk("inv c0 state", 64'(state), 64'd2);
    chk_out("inv c0 out", -30);
    tick();
    chk_out("inv c1 out sat", -65536);
    tick();
    chk_out("inv c2 out sat", -65536);

    // on_time 0: whole period falling, output at offset
    setup(); on_time = 32'd0; offset = 17'd5;
    restart("on0");
    tick();
    chk("on0 c0 state", 64'(state), 64'd4);
    tick();
    chk_out("on0 c1 out", 5);
    chk("on0 c1 state", 64'(state), 64'd4);

    // on_time beyond period: holds at peak across the wrap
    setup(); on_time = 32'd20;
    restart("hold");
    repeat (10) tick();
    chk("hold wrap state", 64'(state), 64'd2);
    chk("hold wrap pulse", 64'(ps), 64'd1);
    chk_out("hold wrap out", 100);
    tick();
    chk("hold next state", 64'(state), 64'd2);
    chk_out("hold next out", 100);
    chk("hold next cr", 64'(cr), 64'd1);

    // clock enable freeze, then asynchronous reset mid-fall
    setup();
    restart("ctl");
    repeat (6) tick();
    chk("ctl c5 state", 64'(state), 64'd3);
    clk_en = 1'b0;
    repeat (5) tick();
    chk("ctl frozen state", 64'(state), 64'd3);
    chk("ctl frozen cr", 64'(cr), 64'd6);
    chk_out("ctl frozen out", 100);
    clk_en = 1'b1;
    tick();
    chk("ctl resume cr", 64'(cr), 64'd7);
    chk_out("ctl resume out", 60);
    #2 rstn = 1'b0;
    #1;
    chk("ctl rst state", 64'(state), 64'd0);
    chk("ctl rst cr", 64'(cr), 64'd0);
    chk_out("ctl rst out", 0);
    @(posedge clk); #1;
    rstn = 1'b1;

`ifdef FG_WAVEFORM_BURST_EN
    // three-period burst, done on the 30th tick, lock until enable toggles
    setup(); burst_len = 8'd3;
    restart("burst");
    for (int t = 1; t < 30; t++) begin
      tick();
      chk($sformatf("burst t%0d done", t), 64'(done), 64'd0);
    end
    tick();
    chk("burst end done", 64'(done), 64'd1);
    chk("burst end state", 64'(state), 64'd0);
    chk("burst end pulse", 64'(ps), 64'd0);
    tick();
    chk("burst locked state", 64'(state), 64'd0);
    chk("burst locked done", 64'(done), 64'd0);
    restart("burst rearm");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
